// File: rtl/ysyx_25040111_fetch_ctrl.sv
// ysyx_25040111_fetch_ctrl: instruction-fetch sequencer for a single-issue core.
// Takes a PC, issues one AXI4-Lite read, holds the instruction for decode until
// execute reports completion, then pulses pc_ready to commit the next PC.
// Optional feature macro: FETCH_TIMEOUT_EN (bus-wait watchdog, fault cause 11).
module ysyx_25040111_fetch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        pc_ready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        exec_done,
    output logic        busy,
    output logic        fetch_err,
    output logic [1:0]  err_cause
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_EXEC   = 3'd3,
        S_COMMIT = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [1:0] CAUSE_BUS     = 2'b01;
    localparam logic [1:0] CAUSE_ALIGN   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [1:0]  cause_q, cause_d;
    logic        timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Bus-wait counter: zero outside the bus phases, so it is clear on entry to ADDR.
    always_comb begin
        wait_cnt_d = 8'd0;
        if (state_q == S_ADDR || state_q == S_DATA) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Fires on the cycle whose increment would reach the limit.
    assign timeout_hit = (state_q == S_ADDR || state_q == S_DATA) &&
                         (wait_cnt_d == TO_LIMIT);
`else
    // Without the watchdog the limit has no effect; the term is constant zero.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and latched-data computation; a handshake wins over the watchdog.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: begin
                if (pc_valid) begin
                    addr_d = pc;
                    if (pc[1:0] != 2'b00) begin
                        state_d = S_HALT;
                        cause_d = CAUSE_ALIGN;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (arready) begin
                    state_d = S_DATA;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DATA: begin
                if (rvalid) begin
                    if (rresp != 2'b00) begin
                        state_d = S_HALT;
                        cause_d = CAUSE_BUS;
                    end else begin
                        inst_d  = rdata;
                        state_d = S_EXEC;
                    end
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Address, instruction and fault-cause registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q  <= 32'd0;
            inst_q  <= 32'd0;
            cause_q <= 2'b00;
        end else begin
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            cause_q <= cause_d;
        end
    end

    // Control outputs decoded purely from the registered state.
    always_comb begin
        arvalid    = (state_q == S_ADDR);
        rready     = (state_q == S_DATA);
        inst_valid = (state_q == S_EXEC);
        pc_ready   = (state_q == S_COMMIT);
        fetch_err  = (state_q == S_HALT);
        busy       = (state_q != S_IDLE);
    end

    assign araddr    = addr_q;
    assign inst_pc   = addr_q;
    assign inst      = inst_q;
    assign err_cause = cause_q;

endmodule

// File: tb/tb_ysyx_25040111_fetch_ctrl.sv
// Testbench for ysyx_25040111_fetch_ctrl: reactive AXI slave / execute stub,
// expected output events queued at issue time, monitor compares as they occur.
module tb_ysyx_25040111_fetch_ctrl;

    localparam int K_ARV  = 0;
    localparam int K_INST = 1;
    localparam int K_PCR  = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int          kind;
        int          start;
        int          width;
        logic [31:0] d;
        logic [31:0] d2;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        exec_done;
    logic        busy;
    logic        fetch_err;
    logic [1:0]  err_cause;

    ysyx_25040111_fetch_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .exec_done(exec_done), .busy(busy), .fetch_err(fetch_err), .err_cause(err_cause)
    );

    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    exp_t sb[$];

    // Slave / execute-stub configuration.
    int          ar_wait = 0, r_wait = 0, ex_wait = 0;
    int          ar_cnt = 0, r_cnt = 0, ex_cnt = 0;
    logic [31:0] rdata_v = 32'd0;
    logic [1:0]  rresp_v = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required below 300000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int st, input int w, input logic [31:0] d,
                        input logic [31:0] d2);
        exp_t e;
        e.kind = k; e.start = st; e.width = w; e.d = d; e.d2 = d2;
        sb.push_back(e);
    endtask

    task automatic check_evt(input int k, input int st, input int w, input logic [31:0] d,
                             input logic [31:0] d2);
        exp_t e;
        if (sb.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, st);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("evt%0d_kind", e.kind), k, e.kind);
        chk($sformatf("evt%0d_start", e.kind), st, e.start);
        chk($sformatf("evt%0d_width", e.kind), w, e.width);
        chk($sformatf("evt%0d_data", e.kind), d, e.d);
        chk($sformatf("evt%0d_data2", e.kind), d2, e.d2);
    endtask

    // Reactive slave and execute stub, driven away from the active edge.
    always @(negedge clk) begin
        if (arvalid) begin
            arready = (ar_cnt == ar_wait);
            ar_cnt++;
        end else begin
            arready = 1'b0;
            ar_cnt  = 0;
        end
        if (rready) begin
            rvalid = (r_cnt == r_wait);
            rdata  = rdata_v;
            rresp  = rresp_v;
            r_cnt++;
        end else begin
            rvalid = 1'b0;
            r_cnt  = 0;
        end
        if (inst_valid) begin
            exec_done = (ex_cnt == ex_wait);
            ex_cnt++;
        end else begin
            exec_done = 1'b0;
            ex_cnt    = 0;
        end
    end

    // Monitor: measures each output window and pops the matching expectation.
    logic        arv_prev = 1'b0, iv_prev = 1'b0, pcr_prev = 1'b0, err_prev = 1'b0;
    int          arv_st = 0, iv_st = 0, pcr_st = 0;
    logic [31:0] arv_addr = 32'd0, iv_inst = 32'd0, iv_pc = 32'd0, pcr_pc = 32'd0;
    logic        arv_stable = 1'b1;

    always @(negedge clk) begin
        if (pc_ready || arvalid) chk("pcready_arvalid_exclusive", 32'(pc_ready && arvalid), 32'd0);
        if (arvalid && !arv_prev) begin
            arv_st = cyc; arv_addr = araddr; arv_stable = 1'b1;
        end
        if (arvalid && araddr != arv_addr) arv_stable = 1'b0;
        if (!arvalid && arv_prev) begin
            chk("araddr_stable", 32'(arv_stable), 32'd1);
            check_evt(K_ARV, arv_st, cyc - arv_st, arv_addr, 32'd0);
        end
        if (inst_valid && !iv_prev) begin
            iv_st = cyc; iv_inst = inst; iv_pc = inst_pc;
        end
        if (!inst_valid && iv_prev) check_evt(K_INST, iv_st, cyc - iv_st, iv_inst, iv_pc);
        if (pc_ready && !pcr_prev) begin
            pcr_st = cyc; pcr_pc = inst_pc;
        end
        if (!pc_ready && pcr_prev) check_evt(K_PCR, pcr_st, cyc - pcr_st, pcr_pc, 32'd0);
        if (fetch_err && !err_prev) check_evt(K_ERR, cyc, 0, 32'(err_cause), 32'd0);
        arv_prev = arvalid; iv_prev = inst_valid; pcr_prev = pc_ready; err_prev = fetch_err;
    end

    // Issue one PC and queue the events it must produce; kill>0 means reset cuts EXEC.
    task automatic issue(input logic [31:0] p, input int a, input int r, input int e,
                         input logic [31:0] d, input logic [1:0] resp, input int kill);
        int c0;
        ar_wait = a; r_wait = r; ex_wait = e; rdata_v = d; rresp_v = resp;
        pc = p; pc_valid = 1'b1; c0 = cyc;
        if (p[1:0] != 2'b00) begin
            push(K_ERR, c0 + 1, 0, 32'd2, 32'd0);
        end else begin
            push(K_ARV, c0 + 1, a + 1, p, 32'd0);
            if (resp != 2'b00) push(K_ERR, c0 + 3 + a + r, 0, 32'd1, 32'd0);
            else if (kill > 0) push(K_INST, c0 + 3 + a + r, kill, d, p);
            else begin
                push(K_INST, c0 + 3 + a + r, e + 1, d, p);
                push(K_PCR, c0 + 4 + a + r + e, 1, p, 32'd0);
            end
        end
        @(negedge clk);
        pc_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy; i++) @(negedge clk);
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_pc_ready"}, 32'(pc_ready), 32'd0);
        chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        chk({tag, "_rready"}, 32'(rready), 32'd0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
        chk({tag, "_err_cause"}, 32'(err_cause), 32'd0);
        chk({tag, "_araddr"}, araddr, 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_inst_pc"}, inst_pc, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_cleared(tag);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; pc = 32'd0; pc_valid = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; exec_done = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset = 1'b1;
        @(negedge clk);

        // Zero-wait fetch, then a back-to-back fetch arriving on the first IDLE cycle.
        issue(32'h8000_0000, 0, 0, 0, 32'h0000_0013, 2'b00, 0);
        wait_idle(20);
        issue(32'h8000_0004, 1, 0, 1, 32'hDEAD_BEEF, 2'b00, 0);
        wait_idle(20);

        // Wait states 3/2/5, with a stray pc_valid during EXEC that must be ignored.
        issue(32'h8000_0008, 3, 2, 5, 32'h0010_0093, 2'b00, 0);
        repeat (8) @(negedge clk);
        chk("exec_during_stray", 32'(inst_valid), 32'd1);
        pc = 32'h8000_0100; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        wait_idle(40);

        // Bus error: sticky HALT, later pc_valid ignored.
        issue(32'h8000_000C, 1, 1, 0, 32'h1234_5678, 2'b10, 0);
        repeat (6) @(negedge clk);
        pc = 32'h8000_0010; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("buserr_fetch_err", 32'(fetch_err), 32'd1);
        chk("buserr_cause", 32'(err_cause), 32'd1);
        chk("buserr_busy", 32'(busy), 32'd1);
        do_reset("after_buserr");

        // Misaligned PC.
        issue(32'h8000_0002, 0, 0, 0, 32'd0, 2'b00, 0);
        chk("misalign_fetch_err", 32'(fetch_err), 32'd1);
        chk("misalign_arvalid", 32'(arvalid), 32'd0);
        chk("misalign_cause", 32'(err_cause), 32'd2);
        do_reset("after_misalign");

`ifdef FETCH_TIMEOUT_EN
        // Timeout after 8 ADDR cycles.
        begin
            int c0;
            ar_wait = 100; pc = 32'h8000_0040; pc_valid = 1'b1; c0 = cyc;
            push(K_ARV, c0 + 1, 8, 32'h8000_0040, 32'd0);
            push(K_ERR, c0 + 9, 0, 32'd3, 32'd0);
            @(negedge clk);
            pc_valid = 1'b0;
            repeat (12) @(negedge clk);
            chk("timeout_fetch_err", 32'(fetch_err), 32'd1);
            chk("timeout_cause", 32'(err_cause), 32'd3);
            chk("timeout_arvalid", 32'(arvalid), 32'd0);
            do_reset("after_timeout");
        end
`else
        // Without the watchdog a long arready stall just waits.
        issue(32'h8000_0040, 40, 0, 0, 32'h0000_0073, 2'b00, 0);
        repeat (30) @(negedge clk);
        chk("nowatchdog_fetch_err", 32'(fetch_err), 32'd0);
        chk("nowatchdog_arvalid", 32'(arvalid), 32'd1);
        wait_idle(80);
`endif

        // Reset while inst_valid is high, then a normal fetch.
        issue(32'h8000_0020, 0, 0, 10, 32'h0000_0517, 2'b00, 3);
        repeat (4) @(negedge clk);
        chk("exec_before_reset", 32'(inst_valid), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_cleared("reset_in_exec");
        reset = 1'b1;
        @(negedge clk);
        issue(32'h8000_0024, 0, 1, 2, 32'h0080_00EF, 2'b00, 0);
        wait_idle(30);

        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            nchk++; nerr++;
            $display("FAIL missing_event: kind %0d expected at cycle %0d never seen", e.kind, e.start);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ysyx_25040111_fetch_ctrl.md
# ysyx_25040111_fetch_ctrl

Instruction-fetch sequencer between the PC unit and the instruction-memory bus. Takes each new PC from the PC unit, issues one AXI4-Lite read, presents the fetched instruction to decode, and waits for execute/writeback to finish. It then pulses the PC unit's `ready` so the next PC is committed. It serialises the single-issue core: one instruction in flight, from PC to retirement.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: bus-wait limit in cycles (only with `FETCH_TIMEOUT_EN`); 8-bit counter.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: reset is synchronous and active-low.
- `pc` in 32: current PC from PC unit.
- `pc_valid` in 1: one-cycle pulse from PC unit, `pc` is new.
- `pc_ready` out 1: to PC unit `ready`; one-cycle pulse commits next PC.
- `araddr` out 32, `arvalid` out 1, `arready` in 1: AXI4-Lite read address channel.
- `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1: AXI4-Lite read data channel.
- `inst` out 32, `inst_pc` out 32, `inst_valid` out 1: fetched instruction to decode; level, held until retire.
- `exec_done` in 1: current instruction has written back.
- `busy` out 1: state ≠ IDLE.
- `fetch_err` out 1, `err_cause` out 2: sticky fault flag and cause (01 bus error, 10 misaligned PC, 11 timeout).

## Operation
States: IDLE, ADDR, DATA, EXEC, COMMIT, HALT. Reset (`reset`=0) forces IDLE, clears all outputs, `inst`/`inst_pc`/`araddr` to 0, `err_cause` to 00.
- IDLE: on `pc_valid`: latch `pc` into `araddr`/`inst_pc`. If `pc[1:0]`≠00, go to HALT with cause 10. Otherwise go to ADDR.
- ADDR: `arvalid`=1, `araddr` stable. On `arready`, go to DATA.
- DATA: `rready`=1. On `rvalid`:
  - `rresp`≠00: go to HALT with cause 01.
  - Otherwise: `inst`←`rdata`, go to EXEC.
- EXEC: `inst_valid`=1. On `exec_done`, go to COMMIT.
- COMMIT: `pc_ready`=1 for exactly one cycle, then go to IDLE.
- HALT: `fetch_err`=1, `err_cause` held. Bus outputs and `inst_valid` are 0. Only reset exits.

Boundary rules:
- `pc_valid` outside IDLE: ignored.
- `exec_done` outside EXEC: ignored.
- `rvalid` is sampled only in DATA. `rvalid` asserted in ADDR, same cycle as `arready`, is not consumed; the slave holds it per AXI.
- `arvalid` never drops before `arready`.
- Reset mid-transaction abandons the bus access; the slave is reset concurrently.
- `pc_ready` and `arvalid` are never high together.

## Timing
- All outputs are registered from state; no combinational input→output path.
- Minimum loop with zero-wait slave and immediate `exec_done`:
  - `pc_valid` at cycle 0.
  - `arvalid` cycles 1 (`arready`=1).
  - `rready` cycle 2 (`rvalid`=1).
  - `inst_valid` cycle 3 (`exec_done`=1).
  - `pc_ready` cycle 4.
  - IDLE cycle 5, with the next `pc_valid` arriving at cycle 5.
- Every extra wait cycle on `arready`, `rvalid` or `exec_done` adds exactly one cycle.
- `fetch_err` asserts in the cycle after the faulting event.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to ADDR and increments each cycle in ADDR or DATA.
  - When it reaches `TIMEOUT_CYCLES` before the data handshake, go to HALT with cause 11; `arvalid`/`rready` drop the next cycle.
- Undefined: no counter; ADDR/DATA wait indefinitely; cause 11 is never produced.

## Test plan
- Zero-wait fetch: `pc`=0x80000000, `pc_valid` pulse, `arready`/`rvalid` immediate, `rdata`=0x00000013, `exec_done` at first `inst_valid` → `araddr`=0x80000000, `inst`=0x00000013, `pc_ready` pulse exactly 4 cycles after `pc_valid`.
- Wait states: `arready` delayed 3 cycles, `rvalid` 2, `exec_done` 5 → `arvalid` stable for 4 cycles, `pc_ready` at cycle 14, single pulse.
- Bus error: `rresp`=10 on `rvalid` → `fetch_err`=1, `err_cause`=01, `inst_valid` never asserts, no `pc_ready`; a later `pc_valid` is ignored.
- Misaligned: `pc`=0x80000002 → no `arvalid`, HALT with `err_cause`=10 next cycle.
- Timeout (`FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): `arready` held 0 → HALT with cause 11 after 8 ADDR cycles, `arvalid`=0 thereafter.
- Reset in EXEC: `reset`=0 for one cycle while `inst_valid`=1 → all outputs 0, IDLE; the next `pc_valid` runs a normal fetch.
